// File: rtl/bht_pkg.sv
// Shared types and constants for the perceptron BHT training sequencer.
package bht_pkg;

  localparam int unsigned GHR_LENGTH      = 10;
  localparam int unsigned NR_ENTRIES      = 1024;
  localparam int unsigned WEIGHT_BITS     = 8;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned VLEN            = 64;

  localparam int unsigned IDX_W      = $clog2(NR_ENTRIES);
  localparam int unsigned ROW_W      = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_DATA_W = (GHR_LENGTH + 1) * WEIGHT_BITS;
  localparam int unsigned SUM_W      = WEIGHT_BITS + $clog2(GHR_LENGTH + 1) + 1;

  typedef logic signed [WEIGHT_BITS-1:0] weight_t;

  typedef struct packed {
    weight_t [GHR_LENGTH-1:0] w;
    weight_t                  bias;
  } perceptron_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
    logic            mispredict;
  } bht_update_t;

  typedef struct packed {
    logic [IDX_W-1:0]      index;
    logic [ROW_W-1:0]      row;
    logic                  taken;
    logic                  mispredict;
    logic [GHR_LENGTH-1:0] ghr;
  } bht_train_entry_t;

  typedef enum logic [1:0] {CLEAR, IDLE, CALC} train_state_e;

  function automatic weight_t sat_step(weight_t w, logic up, int threshold);
    weight_t res;
    if (up) begin
      res = (int'(w) >= threshold) ? weight_t'(threshold) : weight_t'(w + weight_t'(1));
    end else begin
      res = (int'(w) <= -threshold) ? weight_t'(-threshold) : weight_t'(w - weight_t'(1));
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_train_ctrl_if.sv
// Single-ported perceptron table access bus; the sequencer is master.
interface bht_train_ctrl_if;
  import bht_pkg::*;

  logic                  req;
  logic                  we;
  logic [IDX_W-1:0]      addr;
  logic [ROW_W-1:0]      row;
  logic [ROW_DATA_W-1:0] wdata;
  logic [ROW_DATA_W-1:0] rdata;

  modport master (output req, we, addr, row, wdata, input rdata);
  modport slave  (input req, we, addr, row, wdata, output rdata);
endinterface

// File: rtl/bht_train_ctrl_fifo.sv
// Non-fall-through FIFO; a push on a full FIFO is accepted when a pop frees a slot.
module bht_train_ctrl_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  dtype_t data_i,
  output dtype_t data_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0] r_wptr, r_rptr;
  dtype_t         r_mem [DEPTH];
  logic           w_pop_ok, w_push_ok;

  assign empty_o   = (r_wptr == r_rptr);
  assign full_o    = (r_wptr == {~r_rptr[PTR_W], r_rptr[PTR_W-1:0]});
  assign w_pop_ok  = pop_i && !empty_o;
  assign w_push_ok = push_i && (!full_o || w_pop_ok);
  assign data_o    = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (PTR_W + 1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok && !flush_i) r_mem[r_wptr[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/bht_train_ctrl.sv
// Perceptron BHT training sequencer: buffers resolved branches, keeps committed history,
// serialises read/compute/write-back on the table and sweeps it to zero after reset/flush.
module bht_train_ctrl
  import bht_pkg::*;
#(
  parameter int unsigned THRESHOLD       = 30,
  parameter int unsigned TRAIN_THRESHOLD = 30,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  bht_update_t           bht_update_i,
  output logic [GHR_LENGTH-1:0] ghr_comm_o,
  output logic                  restore_spec_o,
  output logic                  busy_o,
  bht_train_ctrl_if.master      tbl,
  output logic [15:0]           drop_cnt_o
);
  localparam int unsigned PTR_W = IDX_W + ROW_W;
  localparam logic [PTR_W-1:0] PTR_LAST = '1;

  train_state_e          r_state, w_state_d;
  logic [PTR_W-1:0]      r_clr_ptr, w_clr_ptr_d;
  bht_train_entry_t      r_entry, w_head, w_push_entry;
  logic [GHR_LENGTH-1:0] r_ghr;
  logic                  r_restore;
  logic [15:0]           r_drop;
  logic                  w_upd, w_pop, w_full, w_empty, w_train;
  perceptron_t           w_row, w_new;
  logic signed [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0]      w_abs;
  logic                  w_unused_pc;

  assign w_unused_pc = ^{bht_update_i.pc[VLEN-1:IDX_W+2], bht_update_i.pc[0]};

  assign w_upd = bht_update_i.valid && !debug_mode_i && !flush_i;

  always_comb begin
    w_push_entry.index      = bht_update_i.pc[IDX_W+1:2];
    w_push_entry.row        = bht_update_i.pc[ROW_W:1];
    w_push_entry.taken      = bht_update_i.taken;
    w_push_entry.mispredict = bht_update_i.mispredict;
    w_push_entry.ghr        = r_ghr;
  end

  bht_train_ctrl_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .dtype_t (bht_train_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_upd),
    .pop_i   (w_pop),
    .data_i  (w_push_entry),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Dot product of the read row with the +/-1 history snapshot, and the trained row.
  always_comb begin
    w_row = perceptron_t'(tbl.rdata);
    w_new = w_row;
    w_sum = SUM_W'($signed(w_row.bias));
    for (int j = 0; j < GHR_LENGTH; j++) begin
      if (r_entry.ghr[j]) w_sum = w_sum + SUM_W'($signed(w_row.w[j]));
      else                w_sum = w_sum - SUM_W'($signed(w_row.w[j]));
      w_new.w[j] = sat_step(w_row.w[j], r_entry.ghr[j] == r_entry.taken, int'(THRESHOLD));
    end
    w_new.bias = sat_step(w_row.bias, r_entry.taken, int'(THRESHOLD));
    w_abs      = w_sum[SUM_W-1] ? SUM_W'(-w_sum) : SUM_W'(w_sum);
    w_train    = (w_abs < SUM_W'(TRAIN_THRESHOLD)) || r_entry.mispredict;
  end

  always_comb begin
    w_state_d   = r_state;
    w_clr_ptr_d = r_clr_ptr;
    w_pop       = 1'b0;
    tbl.req     = 1'b0;
    tbl.we      = 1'b0;
    tbl.addr    = '0;
    tbl.row     = '0;
    tbl.wdata   = '0;
    unique case (r_state)
      CLEAR: begin
        tbl.req               = 1'b1;
        tbl.we                = 1'b1;
        {tbl.addr, tbl.row}   = r_clr_ptr;
        w_clr_ptr_d           = r_clr_ptr + PTR_W'(1);
        if (r_clr_ptr == PTR_LAST) w_state_d = IDLE;
      end
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          tbl.req   = 1'b1;
          tbl.addr  = w_head.index;
          tbl.row   = w_head.row;
          w_state_d = CALC;
        end
      end
      CALC: begin
        if (w_train) begin
          tbl.req   = 1'b1;
          tbl.we    = 1'b1;
          tbl.addr  = r_entry.index;
          tbl.row   = r_entry.row;
          tbl.wdata = w_new;
        end
        w_state_d = IDLE;
      end
      default: w_state_d = CLEAR;
    endcase
    if (flush_i) begin
      w_pop       = 1'b0;
      tbl.req     = 1'b0;
      tbl.we      = 1'b0;
      w_state_d   = CLEAR;
      w_clr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_entry   <= '0;
      r_ghr     <= '0;
      r_restore <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_ptr <= w_clr_ptr_d;
      if (w_pop) r_entry <= w_head;
      if (flush_i)    r_ghr <= '0;
      else if (w_upd) r_ghr <= {r_ghr[GHR_LENGTH-2:0], bht_update_i.taken};
      r_restore <= flush_i || debug_mode_i || (w_upd && bht_update_i.mispredict);
      // The history still shifts for a dropped update; only the table training is lost.
      if (w_upd && w_full && !w_pop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  assign ghr_comm_o     = r_ghr;
  assign restore_spec_o = r_restore;
  assign busy_o         = (r_state == CLEAR);
  assign drop_cnt_o     = r_drop;

endmodule

// File: tb/tb_bht_train_ctrl.sv
// Directed bench for bht_train_ctrl with a behavioural single-ported table.
module tb_bht_train_ctrl;
  import bht_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  flush_i = 1'b0;
  logic                  debug_mode_i = 1'b0;
  bht_update_t           upd = '0;
  logic [GHR_LENGTH-1:0] ghr;
  logic                  restore, busy;
  logic [15:0]           drop;

  bht_train_ctrl_if tbl ();

  bht_train_ctrl #(
    .THRESHOLD       (30),
    .TRAIN_THRESHOLD (30),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .debug_mode_i   (debug_mode_i),
    .bht_update_i   (upd),
    .ghr_comm_o     (ghr),
    .restore_spec_o (restore),
    .busy_o         (busy),
    .tbl            (tbl),
    .drop_cnt_o     (drop)
  );

  always #5 clk = ~clk;

  logic [ROW_DATA_W-1:0] mem [NR_ENTRIES*INSTR_PER_FETCH];
  logic                  ovr_en = 1'b0;
  logic [ROW_DATA_W-1:0] ovr_data = '0;
  int unsigned           wr_cnt = 0;

  always @(posedge clk) begin
    if (tbl.req) begin
      if (tbl.we) begin
        mem[{tbl.addr, tbl.row}] <= tbl.wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        tbl.rdata <= ovr_en ? ovr_data : mem[{tbl.addr, tbl.row}];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic perceptron_t exp_train0(input logic [GHR_LENGTH-1:0] h, input logic t);
    perceptron_t p;
    for (int j = 0; j < GHR_LENGTH; j++) p.w[j] = (h[j] == t) ? 8'sd1 : -8'sd1;
    p.bias = t ? 8'sd1 : -8'sd1;
    return p;
  endfunction

  task automatic drive_upd(input logic [63:0] pc, input logic t, input logic m);
    upd.valid = 1'b1;
    upd.pc = pc;
    upd.taken = t;
    upd.mispredict = m;
  endtask

  task automatic idle_upd();
    upd = '0;
  endtask

  task automatic test_reset();
    int bad;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, tbl.req, tbl.we, restore} !== 4'b1110) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1110", {busy, tbl.req, tbl.we, restore});
    end
    n_cmp++;
    if ({ghr, drop, tbl.addr, tbl.row} !== '0 || tbl.wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: ghr %h drop %h addr %h row %h want all 0",
               ghr, drop, tbl.addr, tbl.row);
    end
    rst_ni = 1'b1;
    bad = 0;
    for (int k = 0; k < 2048; k++) begin
      #1;
      if (busy !== 1'b1 || tbl.req !== 1'b1 || tbl.we !== 1'b1 ||
          {tbl.addr, tbl.row} !== 11'(k) || tbl.wdata !== '0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL clear_sweep: %0d bad cycles, want 0", bad);
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || tbl.req !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_done: busy %b req %b want 0 0", busy, tbl.req);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive_upd(64'h8000_0010, 1'b1, 1'b0);
    @(negedge clk);
    idle_upd();
    #1;
    n_cmp++;
    if ({tbl.req, tbl.we, tbl.addr, tbl.row, ghr, restore} !== {2'b10, 10'd4, 1'b0, 10'h001, 1'b0})
    begin
      n_bad++;
      $display("FAIL basic_read: req %b we %b addr %h row %b ghr %h rs %b want 1 0 004 0 001 0",
               tbl.req, tbl.we, tbl.addr, tbl.row, ghr, restore);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({tbl.req, tbl.we, tbl.addr, tbl.row} !== {2'b11, 10'd4, 1'b0} ||
        tbl.wdata !== exp_train0(10'h000, 1'b1)) begin
      n_bad++;
      $display("FAIL basic_write: req %b we %b addr %h wdata %h want 1 1 004 %h",
               tbl.req, tbl.we, tbl.addr, tbl.wdata, exp_train0(10'h000, 1'b1));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (tbl.req !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: req %b want 0", tbl.req);
    end
  endtask

  task automatic test_saturate();
    logic [ROW_DATA_W-1:0] sat_row;
    sat_row = {11{8'h1E}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_upd(64'h200, 1'b1, 1'b0);
      @(negedge clk);
      idle_upd();
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (ghr !== 10'h3FF) begin
      n_bad++;
      $display("FAIL sat_ghr: got %h want 3ff", ghr);
    end
    ovr_data = sat_row;
    ovr_en = 1'b1;
    @(negedge clk);
    drive_upd(64'h100, 1'b1, 1'b0);
    @(negedge clk);
    idle_upd();
    #1;
    n_cmp++;
    if ({tbl.req, tbl.we, tbl.addr, restore} !== {2'b10, 10'h040, 1'b0}) begin
      n_bad++;
      $display("FAIL sat_read: req %b we %b addr %h rs %b want 1 0 040 0",
               tbl.req, tbl.we, tbl.addr, restore);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (tbl.req !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_nowrite: req %b want 0 (sum 330)", tbl.req);
    end
    @(negedge clk);
    drive_upd(64'h100, 1'b1, 1'b1);
    @(negedge clk);
    idle_upd();
    #1;
    n_cmp++;
    if ({restore, tbl.req, tbl.we} !== 3'b110) begin
      n_bad++;
      $display("FAIL sat_restore: rs %b req %b we %b want 1 1 0", restore, tbl.req, tbl.we);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({tbl.req, tbl.we, tbl.addr} !== {2'b11, 10'h040} || tbl.wdata !== sat_row) begin
      n_bad++;
      $display("FAIL sat_write: req %b we %b addr %h wdata %h want 1 1 040 %h",
               tbl.req, tbl.we, tbl.addr, tbl.wdata, sat_row);
    end
  endtask

  task automatic test_flush();
    int unsigned cnt;
    @(negedge clk);
    drive_upd(64'h100, 1'b1, 1'b1);
    @(negedge clk);
    idle_upd();
    @(negedge clk);
    flush_i = 1'b1;
    cnt = wr_cnt;
    #1;
    n_cmp++;
    if (tbl.req !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_suppress: req %b want 0", tbl.req);
    end
    @(negedge clk);
    flush_i = 1'b0;
    ovr_en = 1'b0;
    #1;
    n_cmp++;
    if (wr_cnt !== cnt) begin
      n_bad++;
      $display("FAIL flush_nowrite: writes %0d want %0d", wr_cnt, cnt);
    end
    n_cmp++;
    if ({busy, tbl.req, tbl.we, tbl.addr, tbl.row, ghr, restore} !==
        {3'b111, 10'd0, 1'b0, 10'h000, 1'b1}) begin
      n_bad++;
      $display("FAIL flush_state: busy %b req %b we %b addr %h row %b ghr %h rs %b want 1 1 1 0 0 0 1",
               busy, tbl.req, tbl.we, tbl.addr, tbl.row, ghr, restore);
    end
  endtask

  task automatic test_overflow();
    logic [5:0]            tk;
    logic [GHR_LENGTH-1:0] hs [4];
    int                    cnt;
    tk = 6'b101101;
    hs[0] = 10'h000; hs[1] = 10'h001; hs[2] = 10'h002; hs[3] = 10'h005;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_upd(64'h10 + 64'(4 * i), tk[5-i], 1'b0);
    end
    @(negedge clk);
    idle_upd();
    #1;
    n_cmp++;
    if ({drop, ghr, busy, restore} !== {16'd2, 10'h02D, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_counts: drop %0d ghr %h busy %b rs %b want 2 02d 1 0",
               drop, ghr, busy, restore);
    end
    cnt = 0;
    while (busy !== 1'b0 && cnt < 3000) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear_timeout: busy %b want 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({tbl.req, tbl.we, tbl.addr, tbl.row} !== {2'b10, 10'(4 + i), 1'b0}) begin
        n_bad++;
        $display("FAIL ovf_read%0d: req %b we %b addr %h want 1 0 %h",
                 i, tbl.req, tbl.we, tbl.addr, 10'(4 + i));
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({tbl.req, tbl.we, tbl.addr} !== {2'b11, 10'(4 + i)} ||
          tbl.wdata !== exp_train0(hs[i], tk[5-i])) begin
        n_bad++;
        $display("FAIL ovf_write%0d: req %b we %b addr %h wdata %h want 1 1 %h %h", i, tbl.req,
                 tbl.we, tbl.addr, tbl.wdata, 10'(4 + i), exp_train0(hs[i], tk[5-i]));
      end
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (tbl.req !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_empty: req %b want 0", tbl.req);
    end
  endtask

  task automatic test_debug();
    @(negedge clk);
    debug_mode_i = 1'b1;
    drive_upd(64'h20, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (restore !== 1'b0) begin
      n_bad++;
      $display("FAIL dbg_pre: rs %b want 0", restore);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({restore, ghr, tbl.req} !== {1'b1, 10'h02D, 1'b0}) begin
        n_bad++;
        $display("FAIL dbg_hold%0d: rs %b ghr %h req %b want 1 02d 0", i, restore, ghr, tbl.req);
      end
    end
    @(negedge clk);
    debug_mode_i = 1'b0;
    idle_upd();
    #1;
    n_cmp++;
    if (restore !== 1'b1) begin
      n_bad++;
      $display("FAIL dbg_lag: rs %b want 1", restore);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({restore, ghr, tbl.req, drop} !== {1'b0, 10'h02D, 1'b0, 16'd2}) begin
      n_bad++;
      $display("FAIL dbg_post: rs %b ghr %h req %b drop %0d want 0 02d 0 2",
               restore, ghr, tbl.req, drop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_flush();
    test_overflow();
    test_debug();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
